// File: rtl/enc_pwm_mixer.sv
// Multi-channel quadrature encoder front end: synchronise, debounce and count detents per channel,
// then drive one PWM output per channel from a shared free-running counter.
module enc_pwm_mixer #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 8,
    parameter int SATURATE = 1,
    parameter int STEP     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*WIDTH-1:0] value_out
);

    localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] VAL_MAX = {WIDTH{1'b1}};

    logic [CHANNELS-1:0] r_a_meta;
    logic [CHANNELS-1:0] r_a_sync;
    logic [CHANNELS-1:0] r_b_meta;
    logic [CHANNELS-1:0] r_b_sync;
    logic [WIDTH-1:0]    r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_meta <= '0;
            r_a_sync <= '0;
            r_b_meta <= '0;
            r_b_sync <= '0;
            r_cnt    <= '0;
        end else begin
            r_a_meta <= enc_a;
            r_a_sync <= r_a_meta;
            r_b_meta <= enc_b;
            r_b_sync <= r_b_meta;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DEBOUNCE-1:0] r_hist_a;
        logic [DEBOUNCE-1:0] r_hist_b;
        logic [DEBOUNCE-1:0] w_hist_a_next;
        logic [DEBOUNCE-1:0] w_hist_b_next;
        logic                r_deb_a;
        logic                r_deb_b;
        logic                r_deb_a_d;
        logic                w_detent;
        logic [WIDTH-1:0]    r_value;
        logic [WIDTH:0]      w_sum;
        logic [WIDTH:0]      w_diff;
        logic [WIDTH-1:0]    w_value_next;
        logic                r_pwm;

        assign w_hist_a_next = {r_hist_a[DEBOUNCE-2:0], r_a_sync[g]};
        assign w_hist_b_next = {r_hist_b[DEBOUNCE-2:0], r_b_sync[g]};

        // The debounced level looks at the history including this edge's sample,
        // so a stable level lands DEBOUNCE+2 edges after it is first sampled.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_hist_a  <= '0;
                r_hist_b  <= '0;
                r_deb_a   <= 1'b0;
                r_deb_b   <= 1'b0;
                r_deb_a_d <= 1'b0;
            end else begin
                r_hist_a  <= w_hist_a_next;
                r_hist_b  <= w_hist_b_next;
                if (&w_hist_a_next)
                    r_deb_a <= 1'b1;
                else if (~|w_hist_a_next)
                    r_deb_a <= 1'b0;
                if (&w_hist_b_next)
                    r_deb_b <= 1'b1;
                else if (~|w_hist_b_next)
                    r_deb_b <= 1'b0;
                r_deb_a_d <= r_deb_a;
            end
        end

        assign w_detent = r_deb_a & ~r_deb_a_d;
        assign w_sum    = {1'b0, r_value} + STEP_W;
        assign w_diff   = {1'b0, r_value} - STEP_W;

        // Carry/borrow out of the extra bit marks the clamp condition.
        always_comb begin
            w_value_next = r_value;
            if (w_detent) begin
                if (!r_deb_b)
                    w_value_next = (SATURATE != 0 && w_sum[WIDTH]) ? VAL_MAX : w_sum[WIDTH-1:0];
                else
                    w_value_next = (SATURATE != 0 && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_value <= '0;
                r_pwm   <= 1'b0;
            end else begin
                r_value <= w_value_next;
                r_pwm   <= (r_cnt < r_value);
            end
        end

        assign value_out[g*WIDTH +: WIDTH] = r_value;
        assign pwm_out[g]                  = r_pwm;
    end

endmodule

// File: tb/tb_enc_pwm_mixer.sv
// Scoreboard bench for enc_pwm_mixer: four configurations side by side, expected
// value_out snapshots queued by the stimulus and consumed by a monitor on every change.
module tb_enc_pwm_mixer;

    localparam int DEB = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  a_def = '0, b_def = '0, a_sat = '0, b_sat = '0, a_wrap = '0, b_wrap = '0;
    logic [3:0]  a_w6 = '0, b_w6 = '0;
    logic [2:0]  pwm_def, pwm_sat, pwm_wrap;
    logic [3:0]  pwm_w6;
    logic [23:0] val_def, val_sat, val_wrap, val_w6;

    enc_pwm_mixer u_def (
        .clk(clk), .reset(reset), .enc_a(a_def), .enc_b(b_def),
        .pwm_out(pwm_def), .value_out(val_def));

    enc_pwm_mixer #(.SATURATE(1), .STEP(16)) u_sat (
        .clk(clk), .reset(reset), .enc_a(a_sat), .enc_b(b_sat),
        .pwm_out(pwm_sat), .value_out(val_sat));

    enc_pwm_mixer #(.SATURATE(0), .STEP(1)) u_wrap (
        .clk(clk), .reset(reset), .enc_a(a_wrap), .enc_b(b_wrap),
        .pwm_out(pwm_wrap), .value_out(val_wrap));

    enc_pwm_mixer #(.CHANNELS(4), .WIDTH(6)) u_w6 (
        .clk(clk), .reset(reset), .enc_a(a_w6), .enc_b(b_w6),
        .pwm_out(pwm_w6), .value_out(val_w6));

    logic [95:0] obs;
    assign obs = {val_w6, val_wrap, val_sat, val_def};

    typedef struct {
        string       name;
        logic [95:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [95:0] m_obs    = '0;
    logic [95:0] m_pushed = '0;
    logic [95:0] last_obs = '0;
    int          total    = 0;
    int          bad      = 0;
    int          cnt;

    // Monitor: every change of the combined value bus must match the next queued snapshot.
    always @(negedge clk) begin
        if (obs !== last_obs) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change act=%0h", obs);
            end else begin
                mon_e = sb_q.pop_front();
                if (obs !== mon_e.exp) begin
                    bad++;
                    $display("FAIL %s act=%0h req=%0h", mon_e.name, obs, mon_e.exp);
                end
            end
            last_obs = obs;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    task automatic set_in(input int inst, input int ch, input logic a, input logic b);
        case (inst)
            0: begin a_def[ch]  = a; b_def[ch]  = b; end
            1: begin a_sat[ch]  = a; b_sat[ch]  = b; end
            2: begin a_wrap[ch] = a; b_wrap[ch] = b; end
            default: begin a_w6[ch] = a; b_w6[ch] = b; end
        endcase
    endtask

    task automatic put_val(input int inst, input int ch, input int nv);
        int w;
        int base;
        w    = (inst == 3) ? 6 : 8;
        base = inst * 24 + ch * w;
        for (int i = 0; i < w; i++)
            m_obs[base + i] = nv[i];
    endtask

    task automatic push(input string name);
        if (m_obs !== m_pushed) begin
            sb_q.push_back('{name, m_obs});
            m_pushed = m_obs;
        end
    endtask

    // One clean detent: B set first, A rises (the detent), A falls, B returns low.
    task automatic detent(input int inst, input int ch, input logic dec, input int nv, input string name);
        @(negedge clk);
        set_in(inst, ch, 1'b0, dec);
        repeat (20) @(negedge clk);
        put_val(inst, ch, nv);
        push(name);
        set_in(inst, ch, 1'b1, dec);
        repeat (20) @(negedge clk);
        set_in(inst, ch, 1'b0, dec);
        repeat (20) @(negedge clk);
        set_in(inst, ch, 1'b0, 1'b0);
        if (dec) repeat (20) @(negedge clk);
    endtask

    task automatic count_pwm(input int inst, input int ch, input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            case (inst)
                0: c += int'(pwm_def[ch]);
                1: c += int'(pwm_sat[ch]);
                2: c += int'(pwm_wrap[ch]);
                default: c += int'(pwm_w6[ch]);
            endcase
        end
    endtask

    initial begin
        int nv;
        repeat (3) @(negedge clk);
        check("rst_value", obs, '0);
        check("rst_pwm", {pwm_w6, pwm_wrap, pwm_sat, pwm_def}, '0);
        reset = 1'b0;

        // Five increments on channel 0, default build.
        for (int k = 0; k < 5; k++)
            detent(0, 0, 1'b0, k + 1, "def_inc");
        count_pwm(0, 0, 256, cnt);
        check("def_pwm_high5", cnt, 5);

        // Saturating STEP=16 build: climb to the ceiling, then down to the floor.
        for (int k = 0; k < 20; k++) begin
            nv = 16 * (k + 1);
            if (nv > 255) nv = 255;
            detent(1, 1, 1'b0, nv, "sat_inc");
        end
        check("sat_ceiling", val_sat[15:8], 8'd255);
        count_pwm(1, 1, 256, cnt);
        check("sat_pwm_high255", cnt, 255);
        for (int k = 0; k < 20; k++) begin
            nv = 255 - 16 * (k + 1);
            if (nv < 0) nv = 0;
            detent(1, 1, 1'b1, nv, "sat_dec");
        end
        check("sat_floor", val_sat[15:8], 8'd0);
        count_pwm(1, 1, 256, cnt);
        check("sat_pwm_zero", cnt, 0);

        // Wrapping build: 0 - 1 = 255, 255 + 1 = 0.
        detent(2, 0, 1'b1, 255, "wrap_dec");
        detent(2, 0, 1'b0, 0, "wrap_inc");

        // Short A glitches on channel 2 must not count.
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            set_in(0, 2, 1'b1, 1'b0);
            repeat (5) @(negedge clk);
            set_in(0, 2, 1'b0, 1'b0);
            repeat (10) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("glitch_no_count", val_def[23:16], 8'd0);

        // Stable rise: value changes on exactly edge DEB+3 after first sampling.
        put_val(0, 2, 1);
        push("def_ch2_timed");
        @(negedge clk);
        set_in(0, 2, 1'b1, 1'b0);
        repeat (DEB + 2) @(posedge clk);
        #1 check("latency_not_early", val_def[23:16], 8'd0);
        @(posedge clk);
        #1 check("latency_on_time", val_def[23:16], 8'd1);
        repeat (20) @(negedge clk);
        set_in(0, 2, 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        // Four channels, WIDTH=6, simultaneous detents.
        for (int c = 0; c < 4; c++)
            put_val(3, c, 1);
        push("w6_simultaneous");
        @(negedge clk);
        a_w6 = 4'hF;
        repeat (30) @(negedge clk);
        a_w6 = 4'h0;
        repeat (20) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            count_pwm(3, c, 64, cnt);
            check($sformatf("w6_pwm_ch%0d_per64", c), cnt, 1);
        end

        // Bring channel 1 to 37, then reset mid-debounce.
        for (int k = 0; k < 37; k++)
            detent(0, 1, 1'b0, k + 1, "def_ch1_inc");
        check("def_ch1_37", val_def[15:8], 8'd37);
        @(negedge clk);
        set_in(0, 1, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        m_obs = '0;
        push("reset_clear");
        reset = 1'b1;
        #1;
        check("midrst_value", val_def, '0);
        check("midrst_pwm", {pwm_w6, pwm_wrap, pwm_sat, pwm_def}, '0);
        @(negedge clk);
        set_in(0, 1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("no_pending_count", val_def, '0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
